cla_addsub_pipe: RTL and testbench
==================================

CLA_ADDSUB_PIPE -- requirements
Module: cla_addsub_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width; legal values are multiples of 4, at least 4.
REQ-002 SHALL have parameter GPS, default 1, number of 4-bit carry-lookahead groups evaluated per pipeline stage; WIDTH/4 SHALL be a multiple of GPS.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, operand beat offered.
REQ-006 SHALL have port in_ready, output, 1, operand beat accepted when high together with in_valid.
REQ-007 SHALL have port a, input, WIDTH, first operand.
REQ-008 SHALL have port b, input, WIDTH, second operand.
REQ-009 SHALL have port sub, input, 1, 0 = a+b, 1 = a-b.
REQ-010 SHALL have port out_valid, output, 1, result beat present.
REQ-011 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-012 SHALL have port res, output, WIDTH, sum/difference.
REQ-013 SHALL have port cout, output, 1, final carry; for subtract, 1 = no borrow.
REQ-014 SHALL have port ovf, output, 1, signed two's-complement overflow.

Function
REQ-015 SHALL compute res = a + (b XOR {WIDTH{sub}}) + sub, modulo 2^WIDTH; cout = bit WIDTH of that sum.
REQ-016 SHALL set ovf = carry into MSB XOR carry out of MSB.
REQ-017 SHALL use 4-bit groups with generate/propagate lookahead inside each group; inter-group carry ripples group to group.
REQ-018 SHALL have latency L = WIDTH/(4*GPS) cycles, accepted beat to out_valid, with no stalls; stage k resolves groups k*GPS .. k*GPS+GPS-1, the carry and the upper operand bits being registered between stages.
REQ-019 SHALL sustain throughput of one beat per cycle when out_ready is held high.
REQ-020 SHALL define advance = !out_valid || out_ready; in_ready = advance; all stages shift only when advance is high (global stall).
REQ-021 SHALL hold res/cout/ovf/out_valid stable while out_valid && !out_ready.
REQ-022 SHALL carry a per-stage valid bit; bubbles propagate as invalid beats and SHALL NOT be collapsed.
REQ-023 SHALL latch sub with the operands at acceptance; later changes on the sub input SHALL NOT affect in-flight beats.
REQ-024 SHALL treat simultaneous output acceptance and input acceptance in one cycle as a normal shift, losing no beat.
REQ-025 SHALL, for boundary operands, produce: all-ones + 1 -> res 0, cout 1; 0 - 1 -> res all-ones, cout 0; MSB-only - 1 -> ovf 1.

Reset
REQ-026 SHALL, while rst_n is low, clear all stage valid bits, out_valid, res, cout and ovf to 0 asynchronously.
REQ-027 SHALL discard all in-flight beats on reset mid-operation; the first output after release SHALL belong to a beat accepted after release.
REQ-028 SHALL drive in_ready high in the first cycle after reset release.

Configuration
REQ-029 SHALL provide macro CLA_ADDSUB_SATURATE_EN. When it is defined, any result with ovf = 1 SHALL be replaced by the signed limit: max positive if the operands (after b inversion) were non-negative, min negative otherwise; ovf still reports the overflow; cout is unchanged.
REQ-030 SHALL, when CLA_ADDSUB_SATURATE_EN is undefined, output the wrapped result and contain no saturation logic.

Structure
REQ-031 SHALL place in shared package cla_pkg: the group width constant CLA_GRP_W = 4 and the typedef of the group gen/prop/carry struct.
REQ-032 SHALL implement each 4-bit lookahead group as the sub-module cla_grp4, with inputs a, b and cin and outputs sum and cout, instantiated WIDTH/4 times.

Verification (WIDTH=16, GPS=1, L=4)
REQ-033 SHALL cover: a=0x1234, b=0x0FFF, sub=0, out_ready=1 -> after 4 cycles res=0x2233, cout=0, ovf=0.
REQ-034 SHALL cover: a=0x0000, b=0x0001, sub=1 -> res=0xFFFF, cout=0, ovf=0; a=0x8000, b=0x0001, sub=1 -> res=0x7FFF (0x8000 with CLA_ADDSUB_SATURATE_EN), ovf=1.
REQ-035 SHALL cover: 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles in order, starting at cycle 4.
REQ-036 SHALL cover: out_ready low for 3 cycles while the pipe is full -> in_ready=0, outputs frozen; on release, beats resume in order with none lost or duplicated.
REQ-037 SHALL cover: rst_n pulsed low with 3 beats in flight -> out_valid=0 immediately; no stale beat appears after release.
REQ-038 SHALL cover: a=0x7FFF, b=0x0001, sub=0 -> ovf=1, res=0x8000 (0x7FFF with CLA_ADDSUB_SATURATE_EN).

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

    localparam int unsigned CLA_GRP_W = 4;

    typedef struct packed {
        logic [CLA_GRP_W-1:0] g;
        logic [CLA_GRP_W-1:0] p;
        logic [CLA_GRP_W:0]   c;
    } cla_gpc_t;

endpackage

// File: rtl/cla_grp4.sv
// 4-bit carry-lookahead group: all internal carries come straight from generate/propagate.
module cla_grp4
    import cla_pkg::*;
(
    input  logic [CLA_GRP_W-1:0] a,
    input  logic [CLA_GRP_W-1:0] b,
    input  logic                 cin,
    output logic [CLA_GRP_W-1:0] sum,
    output logic                 cout
);

    cla_gpc_t gpc;

    always_comb begin
        gpc.g    = a & b;
        gpc.p    = a ^ b;
        gpc.c[0] = cin;
        gpc.c[1] = gpc.g[0] | (gpc.p[0] & cin);
        gpc.c[2] = gpc.g[1] | (gpc.p[1] & gpc.g[0]) | (gpc.p[1] & gpc.p[0] & cin);
        gpc.c[3] = gpc.g[2] | (gpc.p[2] & gpc.g[1]) | (gpc.p[2] & gpc.p[1] & gpc.g[0])
                 | (gpc.p[2] & gpc.p[1] & gpc.p[0] & cin);
        gpc.c[4] = gpc.g[3] | (gpc.p[3] & gpc.g[2]) | (gpc.p[3] & gpc.p[2] & gpc.g[1])
                 | (gpc.p[3] & gpc.p[2] & gpc.p[1] & gpc.g[0])
                 | (gpc.p[3] & gpc.p[2] & gpc.p[1] & gpc.p[0] & cin);
    end

    assign sum  = gpc.p ^ gpc.c[CLA_GRP_W-1:0];
    assign cout = gpc.c[CLA_GRP_W];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor, GPS groups per stage, global-stall handshake.
// Define CLA_ADDSUB_SATURATE_EN to clamp overflowing results to the signed limit.
module cla_addsub_pipe
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GPS   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NGRP = WIDTH / CLA_GRP_W;
    localparam int unsigned SW   = GPS * CLA_GRP_W;
    localparam int unsigned NSTG = NGRP / GPS;

    // Inter-stage registers; index k holds the beat after stage k has resolved its groups.
    logic [WIDTH-1:0] a_q [NSTG];
    logic [WIDTH-1:0] b_q [NSTG];
    logic [WIDTH-1:0] s_q [NSTG];
    logic             c_q [NSTG];
    logic [NSTG-1:0]  v_q;
    logic [WIDTH-1:0] res_q;
    logic             cout_q;
    logic             ovf_q;

    logic [WIDTH-1:0] src_a [NSTG];
    logic [WIDTH-1:0] src_b [NSTG];
    logic [WIDTH-1:0] src_s [NSTG];
    logic             src_c [NSTG];
    logic [NSTG-1:0]  src_v;
    logic [WIDTH-1:0] s_nxt [NSTG];
    logic [WIDTH-1:0] gsum;
    logic [NGRP-1:0]  gcin;
    logic [NGRP-1:0]  gcout;
    logic [WIDTH-1:0] res_d;
    logic             cout_d;
    logic             ovf_d;
    logic             advance;

    assign advance   = !v_q[NSTG-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[NSTG-1];
    assign res       = res_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    // sub is folded into the inverted b and the stage-0 carry, so it travels with the beat.
    always_comb begin
        for (int k = 0; k < int'(NSTG); k++) begin
            if (k == 0) begin
                src_a[k] = a;
                src_b[k] = b ^ {WIDTH{sub}};
                src_s[k] = '0;
                src_c[k] = sub;
                src_v[k] = in_valid;
            end else begin
                src_a[k] = a_q[k-1];
                src_b[k] = b_q[k-1];
                src_s[k] = s_q[k-1];
                src_c[k] = c_q[k-1];
                src_v[k] = v_q[k-1];
            end
        end
    end

    for (genvar j = 0; j < NGRP; j++) begin : g_grp
        localparam int unsigned K = j / GPS;
        if (j % GPS == 0) begin : g_head
            assign gcin[j] = src_c[K];
        end else begin : g_chain
            assign gcin[j] = gcout[j-1];
        end
        cla_grp4 u_grp (
            .a    (src_a[K][j*CLA_GRP_W +: CLA_GRP_W]),
            .b    (src_b[K][j*CLA_GRP_W +: CLA_GRP_W]),
            .cin  (gcin[j]),
            .sum  (gsum[j*CLA_GRP_W +: CLA_GRP_W]),
            .cout (gcout[j])
        );
    end

    always_comb begin
        for (int k = 0; k < int'(NSTG); k++) begin
            for (int i = 0; i < int'(WIDTH); i++) begin
                s_nxt[k][i] = (i / int'(SW) == k) ? gsum[i] : src_s[k][i];
            end
        end
    end

    // Carry into the MSB is recovered from the MSB operand and sum bits.
    always_comb begin
        cout_d = gcout[NGRP-1];
        ovf_d  = src_a[NSTG-1][WIDTH-1] ^ src_b[NSTG-1][WIDTH-1] ^ gsum[WIDTH-1] ^ cout_d;
        res_d  = s_nxt[NSTG-1];
`ifdef CLA_ADDSUB_SATURATE_EN
        if (ovf_d) begin
            res_d = {src_a[NSTG-1][WIDTH-1], {(WIDTH-1){~src_a[NSTG-1][WIDTH-1]}}};
        end
`endif
    end

    for (genvar k = 0; k < NSTG - 1; k++) begin : g_stg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (advance) begin
                a_q[k] <= src_a[k];
                b_q[k] <= src_b[k];
                s_q[k] <= s_nxt[k];
                c_q[k] <= gcout[(k+1)*GPS-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            res_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance) begin
            v_q <= src_v;
            if (src_v[NSTG-1]) begin
                res_q  <= res_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed bench for cla_addsub_pipe (WIDTH=16, GPS=1) with a queue-based scoreboard.
module tb_cla_addsub_pipe;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;

    int           tests = 0;
    int           fails = 0;
    logic [W+1:0] sb [$];
    logic [W+1:0] mon_exp;

    always #5 clk = ~clk;

    cla_addsub_pipe #(.WIDTH(W), .GPS(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: {ovf, cout, res}
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic s);
        logic [W-1:0] yx;
        logic [W:0]   t;
        logic         v;
        logic [W-1:0] r;
        yx = y ^ {W{s}};
        t  = {1'b0, x} + {1'b0, yx} + {{W{1'b0}}, s};
        v  = (x[W-1] == yx[W-1]) && (t[W-1] != x[W-1]);
        r  = t[W-1:0];
`ifdef CLA_ADDSUB_SATURATE_EN
        if (v) r = x[W-1] ? 16'h8000 : 16'h7FFF;
`endif
        return {v, t[W], r};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        bit acc;
        int n;
        n = 0;
        a = x;
        b = y;
        sub = s;
        in_valid = 1'b1;
        do begin
            acc = in_ready;
            tick();
            n++;
        end while (!acc && n < 50);
        if (!acc) check("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        check("drain_empty", sb.size(), 32'd0);
    endtask

    // Output side of the scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 32'd1, 32'd0);
                end else begin
                    mon_exp = sb[0];
                    check("res", res, mon_exp[W-1:0]);
                    check("cout", cout, mon_exp[W]);
                    check("ovf", ovf, mon_exp[W+1]);
                    if (out_ready) void'(sb.pop_front());
                    else check("stall_in_ready", in_ready, 32'd0);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(a, b, sub));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_res", res, 32'd0);
        check("rst_cout", cout, 32'd0);
        check("rst_ovf", ovf, 32'd0);
        tick();
        rst_n = 1'b1;
        check("rel_in_ready", in_ready, 32'd1);

        // Single beat, latency 4
        a = 16'h1234; b = 16'h0FFF; sub = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check("lat_wait", out_valid, 32'd0);
            tick();
        end
        check("lat_valid", out_valid, 32'd1);
        check("lat_res", res, 32'h2233);
        check("lat_cout", cout, 32'd0);
        check("lat_ovf", ovf, 32'd0);
        drain();

        // Boundary operands
        send(16'h0000, 16'h0001, 1'b1);
        send(16'h8000, 16'h0001, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
        drain();

        // 8 back-to-back beats
        for (int t = 1; t <= 12; t++) begin
            if (t <= 8) begin
                a = 16'($urandom);
                b = 16'($urandom);
                sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check("b2b_out_valid", out_valid, {31'd0, (t >= 4 && t <= 11)});
        end
        drain();

        // Full pipe held for 3 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        a = 16'h0F0F; b = 16'h00F1; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("hold_in_ready", in_ready, 32'd0);
            check("hold_out_valid", out_valid, 32'd1);
            tick();
        end
        out_ready = 1'b1;
        send(16'h0F0F, 16'h00F1, 1'b1);
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        drain();

        // Random backpressure
        for (int i = 0; i < 12; i++) begin
            bit acc;
            int n;
            n = 0;
            a = 16'($urandom);
            b = 16'($urandom);
            sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            do begin
                out_ready = ($urandom_range(0, 3) != 0);
                #1;
                acc = in_ready;
                tick();
                n++;
            end while (!acc && n < 50);
            if (!acc) check("bp_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset with 3 beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        tick();
        check("pre_rst_out_valid", out_valid, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 32'd0);
        check("mid_rst_res", res, 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("mid_rel_in_ready", in_ready, 32'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale", out_valid, 32'd0);
        end
        send(16'hFFFF, 16'hFFFF, 1'b1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
